// File: rtl/sram_port_sequencer_if.sv
// Request/response stream bundle between a requester and the SRAM port sequencer.
// The master drives requests and consumes responses; the slave is the sequencer.
interface sram_port_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 33,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic                  req_spare_wen;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_wmask,
    output req_spare_wen,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    input  req_spare_wen,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/sram_port_sequencer.sv
// Converts a valid/ready request stream into 1RW SRAM macro pin activity and returns
// read data in order through a small credit-protected response FIFO.
module sram_port_sequencer #(
  parameter int unsigned DATA_WIDTH = 33,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  sram_port_sequencer_if.slave  bus,
  output logic                  o_sram_csb,
  output logic                  o_sram_web,
  output logic [NUM_WMASKS-1:0] o_sram_wmask,
  output logic                  o_sram_spare_wen,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_din,
  input  logic [DATA_WIDTH-1:0] i_sram_dout,
  output logic [CNT_WIDTH-1:0]  o_rd_count,
  output logic [CNT_WIDTH-1:0]  o_wr_count
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic                  r_rd_pend;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [CNT_WIDTH-1:0]  r_wr_count;

  logic                  w_fire;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [OccW-1:0]       w_occ;
  logic                  w_req_ready;
  logic [CntW-1:0]       w_count_d;
  logic [PtrW-1:0]       w_wr_ptr_d;
  logic [PtrW-1:0]       w_rd_ptr_d;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_d;

  // Credit check counts the read already in flight to the macro, so the FIFO cannot overflow.
  always_comb begin
    w_push      = r_rd_pend;
    w_pop       = (r_count != '0) && bus.rsp_ready;
    w_occ       = OccW'(r_count) + OccW'(r_rd_pend) - OccW'(w_pop);
    w_req_ready = !i_reset && (w_occ < OccW'(RSP_DEPTH));
    w_fire      = bus.req_valid && w_req_ready;
    w_rd_fire   = w_fire && !bus.req_we;
    w_wr_fire   = w_fire && bus.req_we;
  end

  // Macro registers its own inputs, so issue is a straight pass-through.
  always_comb begin
    o_sram_csb       = !w_fire;
    o_sram_web       = !w_wr_fire;
    o_sram_addr      = bus.req_addr;
    o_sram_din       = bus.req_wdata;
    o_sram_wmask     = bus.req_wmask;
    o_sram_spare_wen = bus.req_spare_wen;
  end

  always_comb begin
    w_count_d  = r_count + CntW'(w_push) - CntW'(w_pop);
    w_wr_ptr_d = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_d = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  end

  // Head data is registered so it holds its last value once the FIFO drains.
  always_comb begin
    w_rsp_rdata_d = r_rsp_rdata;
    if (w_count_d != '0) begin
      if (w_push && (w_rd_ptr_d == r_wr_ptr)) begin
        w_rsp_rdata_d = i_sram_dout;
      end else begin
        w_rsp_rdata_d = r_mem[w_rd_ptr_d];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_pend   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_rdata <= '0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      r_rd_pend   <= w_rd_fire;
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rd_count  <= r_rd_count + CNT_WIDTH'(w_rd_fire);
      r_wr_count  <= r_wr_count + CNT_WIDTH'(w_wr_fire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mem[r_wr_ptr] <= i_sram_dout;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_rd_count    = r_rd_count;
  assign o_wr_count    = r_wr_count;

endmodule

// File: tb/tb_sram_port_sequencer.sv
// Bench for sram_port_sequencer: behavioural macro model plus a queue-based reference
// of outstanding reads, credit limit and issue counts.
module tb_sram_port_sequencer;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  sram_port_sequencer_if bus ();

  logic        w_csb;
  logic        w_web;
  logic [3:0]  w_wmask;
  logic        w_spare;
  logic [8:0]  w_addr;
  logic [32:0] w_din;
  logic [32:0] r_dout;
  logic [15:0] w_rd_count;
  logic [15:0] w_wr_count;

  sram_port_sequencer dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .bus              (bus),
    .o_sram_csb       (w_csb),
    .o_sram_web       (w_web),
    .o_sram_wmask     (w_wmask),
    .o_sram_spare_wen (w_spare),
    .o_sram_addr      (w_addr),
    .o_sram_din       (w_din),
    .i_sram_dout      (r_dout),
    .o_rd_count       (w_rd_count),
    .o_wr_count       (w_wr_count)
  );

  function automatic logic [32:0] merge(input logic [32:0] old, input logic [32:0] d,
                                        input logic [3:0] m, input logic sp);
    logic [32:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    if (sp) r[32] = d[32];
    return r;
  endfunction

  // Macro model: dout is only meaningful on the edge after a read.
  logic [32:0] sram_mem [512];
  always @(posedge i_clk) begin
    if (!w_csb && !w_web) begin
      sram_mem[w_addr] <= merge(sram_mem[w_addr], w_din, w_wmask, w_spare);
      r_dout <= 'x;
    end else if (!w_csb) begin
      r_dout <= sram_mem[w_addr];
    end else begin
      r_dout <= 'x;
    end
  end

  typedef struct {
    logic [32:0] d;
    int          vis;
  } rsp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  rsp_t        q[$];
  logic [32:0] ref_mem [512];
  logic [15:0] m_rd = '0;
  logic [15:0] m_wr = '0;
  logic        p_valid, p_pop, p_ready, p_fire;
  logic [32:0] p_rdata;

  task automatic drive(input logic v, input logic we, input logic [8:0] a, input logic [32:0] d,
                       input logic [3:0] m, input logic sp, input logic rr);
    bus.req_valid     = v;
    bus.req_we        = we;
    bus.req_addr      = a;
    bus.req_wdata     = d;
    bus.req_wmask     = m;
    bus.req_spare_wen = sp;
    bus.rsp_ready     = rr;
    p_valid = 1'b0;
    p_rdata = '0;
    if (q.size() > 0) begin
      p_valid = (q[0].vis <= cyc);
      p_rdata = q[0].d;
    end
    p_pop   = p_valid && rr;
    p_ready = !i_reset && ((q.size() - (p_pop ? 1 : 0)) < 2);
    p_fire  = v && p_ready;
    #1;
  endtask

  task automatic tick();
    rsp_t e;
    @(posedge i_clk);
    cyc++;
    if (i_reset) begin
      q.delete();
      m_rd = '0;
      m_wr = '0;
    end else begin
      if (p_pop) void'(q.pop_front());
      if (p_fire) begin
        if (bus.req_we) begin
          ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask,
                                        bus.req_spare_wen);
          m_wr++;
        end else begin
          e.d   = ref_mem[bus.req_addr];
          e.vis = cyc + 1;
          q.push_back(e);
          m_rd++;
        end
      end
    end
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    drive(1'b1, 1'b0, 9'd1, '0, '0, 1'b0, 1'b0);
    checks++; if (bus.req_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    checks++; if (w_csb !== 1'b1 || w_web !== 1'b1) begin failures++;
      $display("FAIL reset_csb_web got=%b%b exp=11", w_csb, w_web); end
    tick();
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 33'h0) begin failures++;
      $display("FAIL reset_rsp got=%b/%h exp=0/0", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (w_rd_count !== 16'd0 || w_wr_count !== 16'd0) begin failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", w_rd_count, w_wr_count); end
    tick();
    i_reset = 1'b0;
    drive(1'b1, 1'b1, 9'd5, 33'h1DEADBEEF, 4'hF, 1'b1, 1'b1);
    checks++; if (bus.req_ready !== 1'b1) begin failures++;
      $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (w_csb !== 1'b0 || w_web !== 1'b0 || w_addr !== 9'd5 || w_din !== 33'h1DEADBEEF)
      begin failures++;
      $display("FAIL write_pins got=%b%b %h %h exp=00 5 1deadbeef", w_csb, w_web, w_addr, w_din);
    end
    tick();
    drive(1'b1, 1'b0, 9'd5, '0, '0, 1'b0, 1'b1);
    checks++; if (w_csb !== 1'b0 || w_web !== 1'b1) begin failures++;
      $display("FAIL read_pins got=%b%b exp=01", w_csb, w_web); end
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++;
      $display("FAIL read_latency_early got=%b exp=0", bus.rsp_valid); end
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 33'h1DEADBEEF) begin failures++;
      $display("FAIL read_after_write got=%b/%h exp=1/1deadbeef", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (w_rd_count !== 16'd1 || w_wr_count !== 16'd1) begin failures++;
      $display("FAIL first_counts got=%0d/%0d exp=1/1", w_rd_count, w_wr_count); end
    tick();
  endtask

  task automatic test_byte_mask();
    drive(1'b1, 1'b1, 9'd7, 33'h011223344, 4'hF, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 9'd7, 33'h1AABBCCDD, 4'b0101, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 9'd7, '0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 33'h011BB33DD) begin failures++;
      $display("FAIL byte_mask got=%b/%h exp=1/011bb33dd", bus.rsp_valid, bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_backpressure();
    int   issued = 0;
    int   got = 0;
    logic rr;
    for (int c = 0; c < 16; c++) begin
      rr = (c >= 6);
      drive(issued < 4, 1'b0, 9'(20 + issued), '0, '0, 1'b0, rr);
      if (c < 4) begin
        checks++; if (bus.req_ready !== (c < 2) || w_csb !== !(c < 2)) begin failures++;
          $display("FAIL bp_credit c=%0d got ready=%b csb=%b exp ready=%b", c, bus.req_ready,
                   w_csb, (c < 2)); end
      end
      if (c == 5) begin
        checks++; if (bus.req_ready !== 1'b0 || w_csb !== 1'b1) begin failures++;
          $display("FAIL bp_stall got ready=%b csb=%b exp 0/1", bus.req_ready, w_csb); end
      end
      if (rr && bus.rsp_valid) begin
        checks++; if (bus.rsp_rdata !== ref_mem[20 + got]) begin failures++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", got, bus.rsp_rdata, ref_mem[20 + got]);
        end
        got++;
      end
      if (p_fire) issued++;
      tick();
    end
    checks++; if (got != 4) begin failures++;
      $display("FAIL bp_count got=%0d exp=4", got); end
  endtask

  task automatic test_streaming();
    int pops = 0;
    apply_reset();
    for (int c = 0; c < 262; c++) begin
      drive(c < 256, 1'b0, 9'($urandom_range(0, 511)), '0, '0, 1'b0, 1'b1);
      if (c < 256) begin
        checks++; if (bus.req_ready !== 1'b1) begin failures++;
          $display("FAIL stream_ready c=%0d got=%b exp=1", c, bus.req_ready); end
      end
      checks++; if (bus.rsp_valid !== p_valid) begin failures++;
        $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, p_valid); end
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_rdata !== p_rdata) begin failures++;
          $display("FAIL stream_data c=%0d got=%h exp=%h", c, bus.rsp_rdata, p_rdata); end
        pops++;
      end
      tick();
    end
    checks++; if (w_rd_count !== 16'd256 || pops != 256) begin failures++;
      $display("FAIL stream_count got rd=%0d pops=%0d exp=256/256", w_rd_count, pops); end
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 9'd3, '0, '0, 1'b0, 1'b1);
    tick();
    i_reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    i_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++;
        $display("FAIL mid_read_stale c=%0d got=%b exp=0", c, bus.rsp_valid); end
      if (c == 0) begin
        checks++; if (w_rd_count !== 16'd0 || w_wr_count !== 16'd0) begin failures++;
          $display("FAIL mid_read_counts got=%0d/%0d exp=0/0", w_rd_count, w_wr_count); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        v, we, sp, rr;
    logic [8:0]  a;
    logic [32:0] d;
    logic [3:0]  m;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      a  = 9'($urandom_range(0, 15));
      d  = {1'($urandom_range(0, 1)), 32'($urandom)};
      m  = 4'($urandom_range(0, 15));
      sp = 1'($urandom_range(0, 1));
      rr = (c >= 390) || ($urandom_range(0, 3) != 0);
      if (c >= 390) v = 1'b0;
      drive(v, we, a, d, m, sp, rr);
      checks++; if (bus.req_ready !== p_ready || w_csb !== !p_fire || w_web !== !(p_fire && we))
        begin failures++;
        $display("FAIL rand_issue c=%0d got rdy/csb/web=%b%b%b exp=%b%b%b", c, bus.req_ready,
                 w_csb, w_web, p_ready, !p_fire, !(p_fire && we));
      end
      if (p_fire) begin
        checks++; if (w_addr !== a || w_din !== d || w_wmask !== m || w_spare !== sp) begin
          failures++;
          $display("FAIL rand_pins c=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", c, w_addr, w_din,
                   w_wmask, w_spare, a, d, m, sp);
        end
      end
      checks++; if (bus.rsp_valid !== p_valid) begin failures++;
        $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, p_valid); end
      if (p_valid) begin
        checks++; if (bus.rsp_rdata !== p_rdata) begin failures++;
          $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus.rsp_rdata, p_rdata); end
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (w_rd_count !== m_rd || w_wr_count !== m_wr) begin failures++;
      $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", w_rd_count, w_wr_count, m_rd, m_wr);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    for (int c = 0; c < 65535; c++) begin
      drive(1'b1, 1'b1, 9'($urandom_range(0, 511)), {1'b0, 32'($urandom)}, 4'hF, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (w_wr_count !== 16'hFFFF) begin failures++;
      $display("FAIL wrap_preload got=%0d exp=65535", w_wr_count); end
    drive(1'b1, 1'b1, 9'd0, '0, 4'hF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (w_wr_count !== 16'd0 || w_rd_count !== 16'd0) begin failures++;
      $display("FAIL wrap got=%0d/%0d exp=0/0", w_wr_count, w_rd_count); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      ref_mem[i]  = sram_mem[i];
    end
    i_reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge i_clk);
    test_reset();
    test_byte_mask();
    test_backpressure();
    test_streaming();
    test_reset_mid_read();
    test_random();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_sequencer.md
# sram_port_sequencer

Single-port request sequencer sitting directly upstream of the 1RW OpenRAM macro (33-bit word with 4 byte-write masks plus spare bit). It converts a valid/ready request stream into the macro's chip-select/write-enable pin protocol, and captures read data one cycle after issue. Read data is returned in order through a 2-entry response FIFO with valid/ready backpressure. Read and write issue counts are kept for the testchip status registers.

## Interface
- DATA_WIDTH, 33, macro word width; bit 32 is the spare bit.
- ADDR_WIDTH, 9, macro address width.
- NUM_WMASKS, 4, byte write-mask width covering bits 31:0.
- RSP_DEPTH, 2, response FIFO entries; fixed at 2 for this revision.
- CNT_WIDTH, 16, width of the issue counters.

Ports:
- clk  in  1  single clock; also drives the macro's clk0.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on the rising edge when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  NUM_WMASKS  byte enables for a write.
- req_spare_wen  in  1  write enable for bit 32.
- rsp_valid  out  1  head of response FIFO valid.
- rsp_ready  in  1  consumer takes the head on the edge when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data at the FIFO head.
- sram_csb  out  1  to macro csb0, active low.
- sram_web  out  1  to macro web0, active low.
- sram_wmask  out  NUM_WMASKS  to macro wmask0.
- sram_spare_wen  out  1  to macro spare_wen0.
- sram_addr  out  ADDR_WIDTH  to macro addr0.
- sram_din  out  DATA_WIDTH  to macro din0.
- sram_dout  in  DATA_WIDTH  from macro dout0.
- rd_count  out  CNT_WIDTH  reads issued since reset; wraps.
- wr_count  out  CNT_WIDTH  writes issued since reset; wraps.

## Operation
- Issue is combinational pass-through, because the macro registers its own inputs:
  - fire = req_valid && req_ready.
  - sram_csb = !fire.
  - sram_web = !(fire && req_we).
  - sram_addr, sram_din, sram_wmask and sram_spare_wen equal the req_* fields.
  - The macro samples these on the same edge that accepts the request.
- When sram_csb = 1, the data outputs may take any value; the macro ignores them.
- Read pending flag rd_pend:
  - Set on the edge that fires a read; otherwise cleared.
  - While set, sram_dout is pushed into the response FIFO on the next edge.
  - sram_dout is sampled only on that edge; it is X at all other times.
- Credit rule, applied to both reads and writes:
  - pop = rsp_valid && rsp_ready.
  - occ = fifo_count + rd_pend - pop.
  - req_ready = !reset && (occ < RSP_DEPTH).
  - The FIFO therefore never overflows.
  - Writes are throttled by the same rule; this is an accepted simplification.
- Response FIFO: in order, 2 entries, with simultaneous push and pop allowed. When empty, rsp_rdata holds its last value.
- Writes produce no response.
- Counters: rd_count increments on a read fire and wr_count on a write fire. Both wrap modulo 2^CNT_WIDTH.
- Reset (synchronous):
  - Clears rd_pend, the FIFO pointers and count, and both counters.
  - req_ready = 0 while reset is high, so sram_csb = 1.
  - A read issued on the edge just before reset asserts is dropped; its data is never presented.

## Timing
- Reset values:
  - rsp_valid = 0.
  - rd_count = 0, wr_count = 0.
  - rsp_rdata = 0.
  - req_ready = 0 while in reset, 1 on the first cycle after.
  - sram_csb = 1, sram_web = 1.
- Read latency: a read fired at edge N is pushed at edge N+1, so rsp_valid = 1 in the cycle after N+1 when the FIFO was empty.
- Throughput:
  - With rsp_ready held at 1, one read per cycle is sustained indefinitely.
  - With rsp_ready = 0, at most 2 further requests are accepted; req_ready then stays 0 until a pop.
- Write visibility: a write fired at edge N is visible to a read fired at edge N+1 or later.
- Combinational paths: rsp_ready -> req_ready -> sram_csb/sram_web. No register sits between them.

## Test plan
- Reset: after reset, write 0x1_DEADBEEF to addr 5 with wmask 4'hF and spare_wen 1, then read addr 5 -> rsp_rdata = 33'h1_DEADBEEF exactly 2 cycles after the read fires; wr_count = 1, rd_count = 1.
- Byte mask:
  - Write 0x0_11223344 to addr 7 with mask F and spare 0.
  - Write 0x1_AABBCCDD with mask 4'b0101 and spare 0.
  - Read addr 7 -> 0x0_11BB33DD.
- Backpressure:
  - Hold rsp_ready = 0 and issue 4 reads -> only 2 fire; req_ready = 0 afterwards; sram_csb stays 1.
  - Release rsp_ready -> all 4 responses return in address order.
- Streaming: 256 back-to-back reads with rsp_ready = 1 -> req_ready never drops; rd_count = 256; data matches a scoreboard.
- Reset mid-read: fire a read, then assert reset on the next edge -> rsp_valid = 0 after reset, no stale response, both counters = 0.
- Counter wrap: preload 65535 write fires -> the next write sets wr_count = 0.
